// File: rtl/wh_rd_arb_pkg.sv
// wh_rd_arb_pkg: shared types and helpers for the WH BRAM read-port arbiter.
package wh_rd_arb_pkg;

    typedef enum logic {IDLE, BURST} state_e;

    localparam int TAG_IDX_W = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wh_rd_arbiter_rr.sv
// rr_arbiter: combinational one-hot pick of the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wh_rd_arbiter.sv
// wh_rd_arbiter: burst-locked arbiter sharing the WH BRAM read port, with a tagged return path.
// WH_RD_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin in IDLE.
module wh_rd_arbiter
    import wh_rd_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WH_ADDR_W  = 18,
    parameter int WH_WIDTH   = 137,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*WH_ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [WH_WIDTH-1:0]            rsp_data_o,
    output logic [WH_ADDR_W-1:0]           WH_BRAM_addrb,
    input  logic [WH_WIDTH-1:0]            WH_BRAM_doutb
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d, gnt_idx, acc_idx;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_idle;
    logic                 accept, acc_last, rel;
    logic [WH_ADDR_W-1:0] acc_addr;
    tag_t                 tag_q [RD_LATENCY+1];

`ifdef WH_RD_ARB_FIXED_PRIO_EN
    assign gnt_idle = req_valid_i & (~req_valid_i + NUM_REQ'(1));
`else
    logic [IW-1:0] rr_q;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid_i),
        .ptr (rr_q),
        .gnt (gnt_idle)
    );

    // The pointer moves past whoever just finished, whether by last or forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_q <= '0;
        else if (rel)
            rr_q <= (int'(acc_idx) == NUM_REQ - 1) ? '0 : acc_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = rel ? IDLE : (accept ? BURST : state_q);
        owner_d = (accept && state_q == IDLE) ? acc_idx : owner_q;
        cnt_d   = rel ? '0 : (accept ? cnt_q + CW'(1) : cnt_q);
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_idle[i]) gnt_idx = IW'(i);
        req_ready_o = !rst_n ? '0 : (state_q == IDLE) ? gnt_idle : NUM_REQ'(1) << owner_q;
        acc_idx     = (state_q == IDLE) ? gnt_idx : owner_q;
        accept      = |(req_valid_i & req_ready_o);
        acc_last    = req_last_i[acc_idx];
        acc_addr    = req_addr_i[int'(acc_idx)*WH_ADDR_W +: WH_ADDR_W];
        rel         = accept && (acc_last || cnt_q + CW'(1) == CW'(MAX_BURST));
    end

    // Tag stage k is live in the cycle RD_LATENCY-k before its data reaches doutb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WH_BRAM_addrb <= '0;
            for (int i = 0; i <= RD_LATENCY; i++)
                tag_q[i] <= '0;
        end else begin
            if (accept)
                WH_BRAM_addrb <= acc_addr;
            tag_q[0] <= {accept, TAG_IDX_W'(acc_idx)};
            for (int i = 1; i <= RD_LATENCY; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid_o[i] = tag_q[RD_LATENCY].valid && tag_q[RD_LATENCY].idx == TAG_IDX_W'(i);
        rsp_data_o = WH_BRAM_doutb;
    end

endmodule

// File: doc/wh_rd_arbiter.md
# wh_rd_arbiter

Shares the single WH BRAM read port (addrb/doutb) between NUM_REQ requesters (DMVM attention-coefficient reader, aggregation reader) downstream of SPMM in the GAT pipeline. Grants whole bursts round-robin, registers the BRAM read address and routes returned data back with a per-beat requester tag through a RD_LATENCY-deep tag pipeline. Sits between the scheduler-level datapath blocks and the WH BRAM.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- WH_ADDR_W, 18, WH BRAM address width
- WH_WIDTH, 137, WH BRAM word width (16×8 data + 8 num_nodes + 1 flag)
- RD_LATENCY, 2, cycles from addrb valid to doutb valid (1..4)
- MAX_BURST, 16, max beats per grant before forced release (power of 2, ≥2)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_addr_i  in  NUM_REQ×WH_ADDR_W  per-requester read address
- req_last_i  in  NUM_REQ  last beat of burst
- req_ready_o  out  NUM_REQ  per-requester beat accept, one-hot or zero
- rsp_valid_o  out  NUM_REQ  read data valid for requester i
- rsp_data_o  out  WH_WIDTH  read data, shared bus
- WH_BRAM_addrb  out  WH_ADDR_W  BRAM read address (registered)
- WH_BRAM_doutb  in  WH_WIDTH  BRAM read data

## Operation
- Beat accepted in cycle c when req_valid_i[i] && req_ready_o[i].
- FSM states IDLE, BURST. Reset → IDLE, rr pointer = 0, beat counter = 0.
- IDLE: grant g = first valid requester at or after rr pointer (wrapping); req_ready_o[g]=1 combinationally same cycle. Accepted beat with last=1 → stay IDLE, rr = g+1 mod NUM_REQ. With last=0 → BURST, owner = g, count = 1.
- BURST: req_ready_o[owner]=1, all others 0. Owner valid low → stall, no beat, stay BURST. Accepted beat increments count; on last=1 or count reaching MAX_BURST → IDLE, rr = owner+1. Forced release leaves requester to re-request remaining beats.
- Requesters must hold addr/last stable while valid && !ready.
- No response backpressure; requesters sink rsp every cycle rsp_valid_o is high.
- rsp_data_o = WH_BRAM_doutb combinational passthrough; meaningful only when some rsp_valid_o bit high.
- Tag pipeline: RD_LATENCY+1 stages of {valid, requester index}.

## Timing
- Reset values: req_ready_o 0 while rst_n low; rsp_valid_o 0; WH_BRAM_addrb 0; tag pipeline cleared.
- Beat accepted in cycle c → WH_BRAM_addrb = addr in cycle c+1 → rsp_valid_o[i]=1 in cycle c+1+RD_LATENCY. Full throughput 1 beat/cycle; in-order per requester.
- WH_BRAM_addrb holds last value when no beat accepted.
- Burst release and new grant: no bubble; IDLE grant is same-cycle.
- Reset asserted mid-burst or with reads in flight: in-flight tags dropped, no rsp_valid_o after reset, rr = 0.
- Single requester active: back-to-back bursts with no gap.

## Configuration
- WH_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins in IDLE, rr pointer unused (removed). Undefined (default): round-robin as above. Burst locking and MAX_BURST apply in both.

## Structure
- Package wh_rd_arb_pkg: state enum typedef (IDLE, BURST), tag struct typedef {valid, idx}, and function clog2-safe index width for NUM_REQ.
- Sub-module rr_arbiter: combinational one-hot pick from request vector and pointer; bypassed under WH_RD_ARB_FIXED_PRIO_EN.

## Test plan
- Single beat: req 0 addr 0x00010, last=1 → ready same cycle, addrb=0x00010 next cycle, rsp_valid_o[0] 3 cycles after accept (RD_LATENCY=2) with model data.
- Contention: both request 4-beat bursts at once, rr=0 → req0 gets beats 0-3, req1 beats 4-7 with no bubble, rsp order matches.
- Stall in burst: req0 drops valid for 3 cycles mid-burst while req1 requests → req1 never granted until req0 last beat.
- Forced release: req0 20-beat burst with last never set, req1 waiting → req0 released after 16 beats, req1 granted next cycle.
- Reset mid-flight: assert rst_n low one cycle after 2 accepted beats → no rsp_valid_o, addrb=0, first post-reset grant goes to req0.
- Fixed priority build: continuous single-beat requests from both → only req0 granted; req1 granted only when req0 idle.
